// File: rtl/seq_pkg.sv
// Shared definitions for the sequence-scan arbiter: controller and detector state encodings
// plus a constant clog2 helper. SEQ_ARB_RR_EN selects round-robin vs fixed-priority in the top.
package seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_ARB  = 4'b0010,
        ST_SCAN = 4'b0100,
        ST_DONE = 4'b1000
    } ctrl_state_t;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_1    = 2'd1,
        D_11   = 2'd2,
        D_110  = 2'd3
    } det_state_t;

    // Smallest r with 2**r >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_det_moore.sv
// Moore "110" detector with overlap. clr forces D_IDLE and wins over en;
// the state only advances on cycles where en is high.
module seq_det_moore
    import seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic dout
);

    det_state_t state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = D_IDLE;
        end else if (en) begin
            unique case (state_q)
                D_IDLE:  state_d = din ? D_1  : D_IDLE;
                D_1:     state_d = din ? D_11 : D_IDLE;
                D_11:    state_d = din ? D_11 : D_110;
                D_110:   state_d = din ? D_1  : D_IDLE;
                default: state_d = D_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= D_IDLE;
        else     state_q <= state_d;
    end

    assign dout = (state_q == D_110);

endmodule

// File: rtl/seq_scan_arb.sv
// Shares one "110" detector among NREQ serial sources, one WIN-bit window per grant.
// Define SEQ_ARB_RR_EN for round-robin arbitration; otherwise the lowest requesting index wins.
module seq_scan_arb
    import seq_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int WIN  = 16,
    localparam int IDW  = clog2(NREQ),
    localparam int CNTW = clog2(WIN + 1),
    localparam int BCW  = clog2(WIN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] seqin,
    output logic [NREQ-1:0] gnt,
    output logic            busy,
    output logic            dout,
    output logic [IDW-1:0]  hit_id,
    output logic [CNTW-1:0] hit_cnt,
    output logic            done,
    output logic            abort
);

    ctrl_state_t     state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            busy_q, busy_d;
    logic [IDW-1:0]  hit_id_q, hit_id_d;
    logic            done_q, done_d;
    logic            abort_q, abort_d;
    logic [BCW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNTW-1:0] det_cnt_q, det_cnt_d;
    logic [IDW-1:0]  win_id;
    logic [IDW-1:0]  cand;
    logic            sample;
    logic            det_clr;

`ifdef SEQ_ARB_RR_EN
    logic [IDW-1:0]  ptr_q, ptr_d;

    // Walk downward so the candidate closest to ptr+1 is the last one written.
    always_comb begin
        win_id = '0;
        cand   = '0;
        for (int i = NREQ; i >= 1; i--) begin
            cand = IDW'((int'(ptr_q) + i) % NREQ);
            if (req[cand]) win_id = cand;
        end
    end
`else
    always_comb begin
        win_id = '0;
        cand   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = IDW'(i);
            if (req[cand]) win_id = cand;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        busy_d    = busy_q;
        hit_id_d  = hit_id_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        bit_cnt_d = bit_cnt_q;
        sample    = 1'b0;
        det_clr   = 1'b0;
`ifdef SEQ_ARB_RR_EN
        ptr_d     = ptr_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_ARB;
                    busy_d  = 1'b1;
                end
            end
            ST_ARB: begin
                det_clr = 1'b1;
                if (|req) begin
                    state_d   = ST_SCAN;
                    hit_id_d  = win_id;
                    gnt_d     = NREQ'(1) << win_id;
                    bit_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            ST_SCAN: begin
                if (!req[hit_id_q]) begin
                    state_d = ST_DONE;
                    gnt_d   = '0;
                    done_d  = 1'b1;
                    abort_d = 1'b1;
                end else begin
                    sample    = 1'b1;
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    if (bit_cnt_q == BCW'(WIN - 1)) begin
                        state_d = ST_DONE;
                        gnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // Detector keeps its last state through DONE, then starts clean.
                det_clr = 1'b1;
`ifdef SEQ_ARB_RR_EN
                ptr_d   = hit_id_q;
`endif
                if (|req) begin
                    state_d = ST_ARB;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // hit_cnt already includes a detection visible this cycle, so DONE shows the final total.
    always_comb begin
        hit_cnt = det_cnt_q;
        if (dout && busy_q && det_cnt_q != {CNTW{1'b1}})
            hit_cnt = det_cnt_q + CNTW'(1);
        det_cnt_d = (state_q == ST_ARB) ? '0 : hit_cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            hit_id_q  <= '0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            bit_cnt_q <= '0;
            det_cnt_q <= '0;
`ifdef SEQ_ARB_RR_EN
            ptr_q     <= IDW'(NREQ - 1);
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            hit_id_q  <= hit_id_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
            bit_cnt_q <= bit_cnt_d;
            det_cnt_q <= det_cnt_d;
`ifdef SEQ_ARB_RR_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    seq_det_moore u_det (
        .clk  (clk),
        .rst  (rst),
        .clr  (det_clr),
        .en   (sample),
        .din  (seqin[hit_id_q]),
        .dout (dout)
    );

    assign gnt    = gnt_q;
    assign busy   = busy_q;
    assign hit_id = hit_id_q;
    assign done   = done_q;
    assign abort  = abort_q;

endmodule

// File: tb/tb_seq_scan_arb.sv
// Directed bench for seq_scan_arb (NREQ=4, WIN=16); grant-order expectations follow SEQ_ARB_RR_EN.
module tb_seq_scan_arb;

    localparam int NREQ = 4;
    localparam int WIN  = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] seqin;
    logic [3:0] gnt;
    logic       busy;
    logic       dout;
    logic [1:0] hit_id;
    logic [4:0] hit_cnt;
    logic       done;
    logic       abort;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_scan_arb #(.NREQ(NREQ), .WIN(WIN)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .seqin   (seqin),
        .gnt     (gnt),
        .busy    (busy),
        .dout    (dout),
        .hit_id  (hit_id),
        .hit_cnt (hit_cnt),
        .done    (done),
        .abort   (abort)
    );

    typedef struct {
        logic [3:0]  req;
        logic [15:0] bits;
        logic [16:0] exp_dout;
        int          exp_hits;
        string       name;
    } vec_t;

    vec_t vecs[4];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r);
        req = r;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int oh_index(input logic [3:0] g);
        int r;
        r = 0;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    task automatic check_all_zero(input string name);
        checkOutput({name, " gnt"}, 32'(gnt), 0);
        checkOutput({name, " busy"}, 32'(busy), 0);
        checkOutput({name, " dout"}, 32'(dout), 0);
        checkOutput({name, " hit_id"}, 32'(hit_id), 0);
        checkOutput({name, " hit_cnt"}, 32'(hit_cnt), 0);
        checkOutput({name, " done"}, 32'(done), 0);
        checkOutput({name, " abort"}, 32'(abort), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge with req already set; returns at the negedge of the DONE cycle.
    task automatic run_window(input string name, input logic [3:0] exp_gnt, input logic [15:0] bits,
                              input logic [16:0] exp_dout, input int exp_hits, input int exp_wait,
                              input int drop_at);
        int waited;
        int idx;
        logic [31:0] ed;
        waited = 0;
        idx    = oh_index(exp_gnt);
        ed     = 32'(exp_dout);
        while (gnt === 4'b0000 && waited < 8) begin
            tick();
            waited++;
        end
        checkOutput({name, " grant latency"}, 32'(waited), 32'(exp_wait));
        checkOutput({name, " hit_id"}, 32'(hit_id), 32'(idx));
        for (int j = 0; j < WIN; j++) begin
            checkOutput($sformatf("%s gnt[%0d]", name, j), 32'(gnt), 32'(exp_gnt));
            checkOutput($sformatf("%s dout[%0d]", name, j), 32'(dout), (ed >> j) & 32'd1);
            seqin = bits[j] ? exp_gnt : ~exp_gnt;
            if (j == drop_at) begin
                req = req & ~exp_gnt;
                tick();
                break;
            end
            tick();
        end
        checkOutput({name, " done"}, 32'(done), 1);
        checkOutput({name, " abort"}, 32'(abort), (drop_at >= 0) ? 32'd1 : 32'd0);
        checkOutput({name, " gnt in DONE"}, 32'(gnt), 0);
        checkOutput({name, " busy in DONE"}, 32'(busy), 1);
        checkOutput({name, " dout in DONE"}, 32'(dout), (ed >> 16) & 32'd1);
        checkOutput({name, " hit_cnt"}, 32'(hit_cnt), 32'(exp_hits));
        checkOutput({name, " hit_id in DONE"}, 32'(hit_id), 32'(idx));
    endtask

    task automatic go_idle(input string name);
        applyStimulus(4'b0000);
        tick();
        checkOutput({name, " idle busy"}, 32'(busy), 0);
        checkOutput({name, " idle done"}, 32'(done), 0);
    endtask

    logic [3:0] rr_exp[4];

    initial begin
        rst   = 1'b0;
        req   = 4'b0000;
        seqin = 4'b0000;
        @(negedge clk);
        do_reset();

        vecs[0] = '{4'b0001, 16'h001B, 17'h00048, 2, "basic ch0"};
        vecs[1] = '{4'b1000, 16'h0037, 17'h00090, 2, "overlap ch3"};
        vecs[2] = '{4'b0010, 16'h6000, 17'h10000, 1, "lastbit ch1"};
        vecs[3] = '{4'b0100, 16'hB6DB, 17'h09248, 5, "repeat ch2"};

        for (int v = 0; v < 4; v++) begin
            applyStimulus(vecs[v].req);
            run_window(vecs[v].name, vecs[v].req, vecs[v].bits, vecs[v].exp_dout,
                       vecs[v].exp_hits, 2, -1);
            go_idle(vecs[v].name);
        end

        // All four requesting: back-to-back windows, two grant-low cycles between them.
`ifdef SEQ_ARB_RR_EN
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
`else
        rr_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
        do_reset();
        applyStimulus(4'b1111);
        for (int w = 0; w < 4; w++) begin
            run_window($sformatf("arb win%0d", w), rr_exp[w], 16'h0000, 17'h00000, 0, 2, -1);
        end
        go_idle("arb");

        // Drop ch2's request while it holds D_11; the would-be detecting 0 must be ignored.
        do_reset();
        applyStimulus(4'b0100);
        run_window("abort ch2", 4'b0100, 16'h0018, 17'h00000, 0, 2, 5);
        tick();
        checkOutput("abort idle busy", 32'(busy), 0);
        checkOutput("abort idle done", 32'(done), 0);

        // Reset in the middle of a window with the detector in D_11.
        do_reset();
        applyStimulus(4'b0010);
        tick();
        tick();
        seqin = 4'b0010;
        tick();
        seqin = 4'b0010;
        tick();
        checkOutput("pre-rst gnt", 32'(gnt), 32'h2);
        rst = 1'b1;
        #1;
        check_all_zero("mid-scan rst");
        @(negedge clk);
        rst = 1'b0;
        run_window("post-rst ch1", 4'b0010, 16'h0000, 17'h00000, 0, 2, -1);
        go_idle("post-rst");

        // ch1 ends on 1,1 and ch2 opens with 0: the detector must not carry over.
        do_reset();
        applyStimulus(4'b0110);
        run_window("bnd ch1", 4'b0010, 16'hC000, 17'h00000, 0, 2, -1);
        applyStimulus(4'b0100);
        run_window("bnd ch2", 4'b0100, 16'h0000, 17'h00000, 0, 2, -1);
        go_idle("bnd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_scan_arb.md
# seq_scan_arb

Scheduler that shares one Moore "110" pattern detector among NREQ serial sources. Sources raise a request; the block grants one source at a time, using round-robin or fixed priority. It then streams WIN bits from the granted source through the detector. It reports detections tagged with the channel id and pulses done at the end of each window. It sits between the serial front-end lanes and the event logger.

## Interface
- NREQ, 4, number of requesting serial sources (2..8)
- WIN, 16, bits sampled per grant window (2..255)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  NREQ  per-source request, level; held while the source wants service
- seqin  input  NREQ  per-source serial bit
- gnt  output  NREQ  one-hot grant, registered
- busy  output  1  high in ARB, SCAN and DONE
- dout  output  1  Moore detector output; high in each cycle the detector is in state D110
- hit_id  output  clog2(NREQ)  index of the granted channel; valid whenever busy is high
- hit_cnt  output  clog2(WIN+1)  number of detections in the current window, counted up to and including the detection that appears in DONE; valid in DONE
- done  output  1  one-cycle pulse in DONE
- abort  output  1  qualifies done; high when the window ended because req was dropped

## Operation
- Controller FSM has four states: IDLE, ARB, SCAN, DONE.
  - IDLE: when any req bit is high, go to ARB.
  - ARB: select a winner, load hit_id, clear the detector and the bit counter, go to SCAN. If req has dropped to zero, return to IDLE.
  - SCAN: each cycle, sample seqin[hit_id] into the detector and increment the bit counter.
    - Go to DONE after the sample where counter equals WIN-1 (normal end).
    - Go to DONE early if req[hit_id] is low; that cycle's bit is not sampled and abort is set.
  - DONE: pulse done, drop gnt, update the round-robin pointer to hit_id. If any req is high, go to ARB, otherwise go to IDLE.
- Detector (Moore, overlap allowed). States and transitions:
  - D_IDLE: 1 goes to D_1, 0 stays in D_IDLE.
  - D_1: 1 goes to D_11, 0 goes to D_IDLE.
  - D_11: 1 stays in D_11, 0 goes to D_110.
  - D_110: 1 goes to D_1, 0 goes to D_IDLE.
  - dout = 1 only in D_110.
  - Every state has a defined next state; there are no latches.
- Detector advances only in SCAN. It holds its state in DONE and is forced to D_IDLE in ARB and on reset.
- hit_cnt increments on each cycle where dout is high while busy. It clears in ARB and saturates at all-ones.
- Round-robin search starts at pointer+1 modulo NREQ. The pointer resets to NREQ-1, so channel 0 wins first.

## Timing
- Reset values: controller in IDLE, detector in D_IDLE, pointer NREQ-1. Outputs gnt=0, busy=0, dout=0, hit_id=0, hit_cnt=0, done=0, abort=0.
- Request-to-grant latency: req high before edge t; ARB occupies cycle t; gnt is high from edge t+1. Minimum 2 cycles from an idle bus.
- A source must present bit k in the k-th cycle in which gnt is high. A full window holds gnt for exactly WIN cycles.
- dout lags the sampled '0' by one edge. A detection on the last bit appears in the DONE cycle.
- Back-to-back windows: DONE goes to ARB, so gnt is low for 2 cycles between windows.
- A single requester re-arbitrates to itself.
- rst asserted mid-window clears all state immediately. No done pulse is produced.
- A new req during SCAN does not preempt the current window.

## Configuration
- SEQ_ARB_RR_EN
  - Defined: round-robin arbitration as described above.
  - Undefined: fixed priority, where the lowest index wins. The pointer register is removed.

## Structure
- Shared package seq_pkg holds:
  - Controller state encoding as one-hot 4-bit constants: IDLE=0001, ARB=0010, SCAN=0100, DONE=1000.
  - Detector state constants.
  - A function computing clog2.
- One sub-module, seq_det_moore, contains the detector. Ports: clk, rst, clr, en, din, dout.
- Arbitration, counters and the controller FSM are in the top module.

## Test plan
- Reset, then req=0001 and ch0 stream 1,1,0,1,1,0, then 0s, with WIN=16 -> gnt=0001 two cycles after req; dout high two times; hit_cnt=2 at done; abort=0.
- Overlap check: ch0 stream 1,1,1,0,1,1,0 -> dout pulses after bit index 3 and bit index 6; hit_cnt=2.
- req=1111 held for 4 windows -> grants in order 0001, 0010, 0100, 1000; with SEQ_ARB_RR_EN undefined -> 0001 repeated.
- Drop req[2] after 5 SCAN cycles while ch2 is granted -> next cycle is DONE with done=1 and abort=1; ch2's sixth bit is ignored.
- Assert rst mid-SCAN with the detector in D_11 -> all outputs 0 immediately; next window does not detect a match on a leading 0.
- Window boundary: ch1 ends its window with 1,1 and ch2 starts with 0 -> no dout in ch2's window.
